// File: rtl/fir_i2c_slave.sv
// Write-only I2C slave that streams received bytes into the FIR coefficient/config shift register.
// SCL/SDA are oversampled by clk; the slave only ever pulls SDA low for ACK and never touches SCL.
module fir_i2c_slave #(
    parameter logic [6:0] I2C_ADDRESS = 7'h50,
    parameter int         NTAPS       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inout  wire                   scl_inout,
    inout  wire                   sda_inout,
    input  logic                  ack_in,
    output logic                  start_out,
    output logic                  stop_out,
    output logic [NTAPS*16-1:0]   data_out,
    output logic                  valid_out
);

    localparam int DW = NTAPS * 16;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      scl_sync, sda_sync;
    logic            scl_d, sda_d;
    logic            scl_s, sda_s;
    logic            scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_w;
    logic [DW-1:0]   data_d;
    logic            valid_d, start_d, stop_d;
    logic            sda_low_q, sda_low_d;
    logic            ack_phase_q, ack_phase_d;

    // Bus idles high, so synchronizers reset to 1 to avoid phantom edges after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_inout};
            sda_sync <= {sda_sync[0], sda_inout};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            data_out    <= '0;
            valid_out   <= 1'b0;
            start_out   <= 1'b0;
            stop_out    <= 1'b0;
            sda_low_q   <= 1'b0;
            ack_phase_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_out    <= data_d;
            valid_out   <= valid_d;
            start_out   <= start_d;
            stop_out    <= stop_d;
            sda_low_q   <= sda_low_d;
            ack_phase_q <= ack_phase_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_out;
        valid_d     = 1'b0;
        start_d     = 1'b0;
        stop_d      = 1'b0;
        sda_low_d   = sda_low_q;
        ack_phase_d = ack_phase_q;
        byte_w      = {shift_q[6:0], sda_s};

        if (stop_det) begin
            state_d     = IDLE;
            bit_cnt_d   = 4'd0;
            sda_low_d   = 1'b0;
            ack_phase_d = 1'b0;
            stop_d      = 1'b1;
        end else if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = 4'd0;
            sda_low_d   = 1'b0;
            ack_phase_d = 1'b0;
            start_d     = 1'b1;
        end else begin
            case (state_q)
                ADDR, DATA: begin
                    if (scl_rise) begin
                        shift_d = byte_w;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd8;
                            if (state_q == DATA) begin
                                data_d  = {data_out[DW-9:0], byte_w};
                                valid_d = 1'b1;
                                state_d = DATA_ACK;
                            end else if (byte_w[7:1] == I2C_ADDRESS && !byte_w[0]) begin
                                data_d  = {data_out[DW-9:0], byte_w};
                                valid_d = 1'b1;
                                state_d = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            bit_cnt_d = 4'(bit_cnt_q + 4'd1);
                        end
                    end
                end
                // First SCL fall opens the ACK slot (ack_in sampled here), second fall closes it.
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            ack_phase_d = 1'b1;
                            sda_low_d   = (state_q == ADDR_ACK) || !ack_in;
                        end else begin
                            ack_phase_d = 1'b0;
                            sda_low_d   = 1'b0;
                            bit_cnt_d   = 4'd0;
                            state_d     = DATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Gating with rst_n keeps the release combinational while reset is held.
    assign sda_inout = (sda_low_q && rst_n) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_fir_i2c_slave.sv
// Directed/randomized I2C master driving fir_i2c_slave, checked against a byte-level model.
module tb_fir_i2c_slave;

  localparam logic [6:0] ADDR = 7'h50;
  localparam int NTAPS = 8;
  localparam int DW = NTAPS * 16;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ack_in = 1'b0;
  logic m_scl_low = 1'b0;
  logic m_sda_low = 1'b0;
  logic edge_pos = 1'b0;
  wire scl_bus;
  wire sda_bus;
  logic start_out, stop_out, valid_out;
  logic [DW-1:0] data_out;

  pullup (scl_bus);
  pullup (sda_bus);
  assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;

  fir_i2c_slave #(.I2C_ADDRESS(ADDR), .NTAPS(NTAPS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scl_inout(scl_bus),
    .sda_inout(sda_bus),
    .ack_in(ack_in),
    .start_out(start_out),
    .stop_out(stop_out),
    .data_out(data_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as an extra count.
  int valid_cnt = 0;
  int start_cnt = 0;
  int stop_cnt = 0;
  logic [DW-1:0] valid_snap = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        valid_cnt++;
        valid_snap = data_out;
      end
      if (start_out) start_cnt++;
      if (stop_out) stop_cnt++;
    end
  end

  // Reference model state
  logic [DW-1:0] exp_data = '0;
  int exp_valid = 0;
  int exp_start = 0;
  int exp_stop = 0;
  logic session_ok = 1'b0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (edge_pos) @(posedge clk);
    else @(negedge clk);
  endtask

  task automatic wait_n(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0;
    wait_n(HALF);
    m_scl_low = 1'b0;
    wait_n(HALF);
    m_sda_low = 1'b1;
    wait_n(HALF);
    m_scl_low = 1'b1;
    wait_n(2);
    exp_start++;
    session_ok = 1'b0;
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1;
    wait_n(HALF);
    m_scl_low = 1'b0;
    wait_n(HALF);
    m_sda_low = 1'b0;
    wait_n(HALF);
    exp_stop++;
    session_ok = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = !b;
    wait_n(HALF);
    m_scl_low = 1'b0;
    wait_n(HALF);
    m_scl_low = 1'b1;
    wait_n(2);
  endtask

  task automatic ack_slot(output logic seen);
    m_sda_low = 1'b0;
    wait_n(HALF);
    m_scl_low = 1'b0;
    wait_n(3);
    seen = sda_bus;
    wait_n(HALF - 3);
    m_scl_low = 1'b1;
    wait_n(2);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag, input logic expect_ack);
    logic seen;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    ack_slot(seen);
    check({tag, " ack_slot_sda"}, DW'(seen), DW'(!expect_ack));
  endtask

  task automatic check_model(input string tag);
    check({tag, " valid_count"}, DW'(valid_cnt), DW'(exp_valid));
    check({tag, " data_out"}, data_out, exp_data);
    if (exp_valid > 0) check({tag, " data_at_valid"}, valid_snap, exp_data);
  endtask

  // Address byte: accepted only for our address with a write request.
  task automatic xfer_addr(input logic [7:0] b, input string tag);
    logic accepted;
    accepted = (b[7:1] == ADDR) && (b[0] == 1'b0);
    send_byte(b, tag, accepted);
    if (accepted) begin
      exp_data = {exp_data[DW-9:0], b};
      exp_valid++;
    end
    session_ok = accepted;
    check_model(tag);
  endtask

  task automatic xfer_data(input logic [7:0] b, input logic nack, input string tag);
    ack_in = nack;
    send_byte(b, tag, session_ok && !nack);
    if (session_ok) begin
      exp_data = {exp_data[DW-9:0], b};
      exp_valid++;
    end
    check_model(tag);
  endtask

  task automatic check_bus_counts(input string tag);
    check({tag, " start_count"}, DW'(start_cnt), DW'(exp_start));
    check({tag, " stop_count"}, DW'(stop_cnt), DW'(exp_stop));
    check({tag, " sda_released"}, DW'(sda_bus), DW'(1'b1));
  endtask

  initial begin
    logic [7:0] rb;
    logic rack;
    logic [7:0] partial;

    repeat (4) @(negedge clk);
    check("reset start_out", DW'(start_out), '0);
    check("reset stop_out", DW'(stop_out), '0);
    check("reset valid_out", DW'(valid_out), '0);
    check("reset data_out", data_out, '0);
    check("reset sda", DW'(sda_bus), DW'(1'b1));
    rst_n = 1'b1;
    wait_n(5);

    // Address-only write
    bus_start();
    xfer_addr({ADDR, 1'b0}, "addr_only");
    check("addr_only low byte", DW'(data_out[7:0]), DW'({ADDR, 1'b0}));
    bus_stop();
    wait_n(4);
    check_bus_counts("addr_only");

    // Two data bytes with ACK
    bus_start();
    xfer_addr({ADDR, 1'b0}, "ab_addr");
    xfer_data(8'hA5, 1'b0, "ab_a5");
    xfer_data(8'h3C, 1'b0, "ab_3c");
    check("ab data24", DW'(data_out[23:0]), DW'({ADDR, 1'b0, 8'hA5, 8'h3C}));
    bus_stop();
    wait_n(4);
    check_bus_counts("ab");

    // Random bytes with random ACK/NACK, one forced NACK
    bus_start();
    xfer_addr({ADDR, 1'b0}, "rnd_addr");
    xfer_data(8'($urandom_range(0, 255)), 1'b1, "rnd_nack");
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      rack = 1'($urandom_range(0, 1));
      xfer_data(rb, rack, "rnd_data");
    end
    ack_in = 1'b0;
    bus_stop();
    wait_n(4);
    check_bus_counts("rnd");

    // Wrong address, then read request: both ignored
    bus_start();
    xfer_addr({ADDR ^ 7'h01, 1'b0}, "wrong_addr");
    xfer_data(8'h77, 1'b0, "wrong_data");
    bus_stop();
    bus_start();
    xfer_addr({ADDR, 1'b1}, "read_req");
    xfer_data(8'h99, 1'b0, "read_data");
    bus_stop();
    bus_start();
    xfer_addr({ADDR, 1'b0}, "after_ign_addr");
    xfer_data(8'h12, 1'b0, "after_ign_data");
    bus_stop();
    wait_n(4);
    check_bus_counts("ignore");

    // Repeated START after 4 data bits discards the partial byte
    bus_start();
    xfer_addr({ADDR, 1'b0}, "rs_addr");
    partial = 8'($urandom_range(0, 255));
    for (int i = 7; i >= 4; i--) send_bit(partial[i]);
    bus_start();
    xfer_addr({ADDR, 1'b0}, "rs_addr2");
    xfer_data(8'h5A, 1'b0, "rs_data");
    bus_stop();
    wait_n(4);
    check_bus_counts("rs");

    // Bus edges coincident with posedge clk
    edge_pos = 1'b1;
    bus_start();
    xfer_addr({ADDR, 1'b0}, "pos_addr");
    xfer_data(8'($urandom_range(0, 255)), 1'b0, "pos_d0");
    xfer_data(8'($urandom_range(0, 255)), 1'b0, "pos_d1");
    bus_stop();
    edge_pos = 1'b0;
    wait_n(4);
    check_bus_counts("pos");

    // Reset while the slave is pulling SDA low for an address ACK
    bus_start();
    rb = {ADDR, 1'b0};
    for (int i = 7; i >= 0; i--) send_bit(rb[i]);
    m_sda_low = 1'b0;
    wait_n(6);
    check("pre_reset ack drive", DW'(sda_bus), DW'(1'b0));
    rst_n = 1'b0;
    #1;
    check("mid_reset sda", DW'(sda_bus), DW'(1'b1));
    check("mid_reset valid_out", DW'(valid_out), '0);
    check("mid_reset start_out", DW'(start_out), '0);
    check("mid_reset stop_out", DW'(stop_out), '0);
    check("mid_reset data_out", data_out, '0);
    exp_data = '0;
    valid_cnt = exp_valid;
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    wait_n(4);
    rst_n = 1'b1;
    wait_n(4);

    // Fresh transaction after reset
    bus_start();
    xfer_addr({ADDR, 1'b0}, "post_rst_addr");
    xfer_data(8'hC3, 1'b0, "post_rst_data");
    check("post_rst data16", DW'(data_out[15:0]), DW'({ADDR, 1'b0, 8'hC3}));
    bus_stop();
    wait_n(4);
    check_bus_counts("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
